// File: rtl/bias_bank_buffer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : bias_bank_buffer_if                                             |
// | Purpose  : Bundles the bias load stream, swap control, status flags and    |
// |            active-bank read-out of bias_bank_buffer.                       |
// | Signals  : load_start, in_valid, in_data, in_ready  - serial bias load     |
// |            load_done, load_count                    - load progress        |
// |            swap, active_valid, err_overflow         - commit / status      |
// |            bias_flat, rd_idx, rd_data               - active bank read-out |
// | Modports : master (producer / consumer side), slave (the buffer)           |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
interface bias_bank_buffer_if #(
  parameter int NUM_CH = 64,
  parameter int BIAS_W = 16,
  parameter int OUT_W  = 16,
  parameter int IDX_W  = $clog2(NUM_CH)
) ();
  logic                    load_start;
  logic                    in_valid;
  logic [BIAS_W-1:0]       in_data;
  logic                    in_ready;
  logic                    load_done;
  logic [IDX_W:0]          load_count;
  logic                    swap;
  logic                    active_valid;
  logic                    err_overflow;
  logic [NUM_CH*OUT_W-1:0] bias_flat;
  logic [IDX_W-1:0]        rd_idx;
  logic [OUT_W-1:0]        rd_data;

  modport master (
    output load_start, in_valid, in_data, swap, rd_idx,
    input  in_ready, load_done, load_count, active_valid, err_overflow,
           bias_flat, rd_data
  );

  modport slave (
    input  load_start, in_valid, in_data, swap, rd_idx,
    output in_ready, load_done, load_count, active_valid, err_overflow,
           bias_flat, rd_data
  );
endinterface
`default_nettype wire

// File: rtl/bias_bank_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : bias_bank_buffer                                                |
// | Purpose  : Double-buffered bias store. Biases stream serially into a       |
// |            shadow bank; a swap commits it to the active bank that drives   |
// |            the compute array, so the next layer can load meanwhile.        |
// | Ports    : clk      - clock, rising edge                                   |
// |            bias_rst - asynchronous active-high reset                       |
// |            bus      - bias_bank_buffer_if.slave (load stream, swap,        |
// |                       status flags, flat bus and indexed read port)        |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module bias_bank_buffer #(
  parameter int NUM_CH = 64,
  parameter int BIAS_W = 16,
  parameter int OUT_W  = 16,
  parameter int IDX_W  = $clog2(NUM_CH)
) (
  input logic               clk,
  input logic               bias_rst,
  bias_bank_buffer_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_FULL = 2'd2
  } state_t;

  localparam logic [IDX_W:0] C_LAST   = (IDX_W+1)'(NUM_CH - 1);
  localparam logic [IDX_W:0] C_NUM_CH = (IDX_W+1)'(NUM_CH);

  state_t              r_state;
  state_t              w_state_nxt;
  logic                w_accept;
  logic                w_commit;
  logic                w_restart;
  logic                w_err_set;

  logic [BIAS_W-1:0]   r_shadow [NUM_CH];
  logic [BIAS_W-1:0]   r_active [NUM_CH];
  logic [IDX_W:0]      r_load_count;
  logic                r_in_ready;
  logic                r_load_done;
  logic                r_active_valid;
  logic                r_err_overflow;
  logic [OUT_W-1:0]    r_rd_data;
  logic [BIAS_W-1:0]   w_rd_src;

  function automatic logic [OUT_W-1:0] sext(input logic [BIAS_W-1:0] b);
    return OUT_W'($signed(b));
  endfunction

  // Next-state / control decode
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_commit    = 1'b0;
    w_restart   = 1'b0;
    w_err_set   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.load_start) begin
          w_restart   = 1'b1;
          w_state_nxt = S_LOAD;
        end
        if (bus.in_valid) w_err_set = 1'b1;
      end
      S_LOAD: begin
        // A restart takes priority: the beat offered alongside it is dropped.
        if (bus.load_start) begin
          w_restart = 1'b1;
        end else if (bus.in_valid && r_in_ready) begin
          w_accept = 1'b1;
          if (r_load_count == C_LAST) w_state_nxt = S_FULL;
        end
      end
      S_FULL: begin
        // Commit is evaluated before a same-cycle restart so the set is not lost.
        if (bus.swap) begin
          w_commit    = 1'b1;
          w_state_nxt = S_IDLE;
        end
        if (bus.load_start) begin
          w_restart   = 1'b1;
          w_state_nxt = S_LOAD;
        end
        if (bus.in_valid) w_err_set = 1'b1;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register and state-derived flags
  always_ff @(posedge clk or posedge bias_rst) begin
    if (bias_rst) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b0;
      r_load_done <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_in_ready  <= (w_state_nxt == S_LOAD);
      r_load_done <= (w_state_nxt == S_FULL);
    end
  end

  // Read source; during a commit the shadow bank is read so rd_data
  // shows the new set in the same cycle bias_flat does.
  always_comb begin
    w_rd_src = '0;
    if ({1'b0, bus.rd_idx} < C_NUM_CH) begin
      w_rd_src = w_commit ? r_shadow[bus.rd_idx] : r_active[bus.rd_idx];
    end
  end

  // Banks, counters and status
  always_ff @(posedge clk or posedge bias_rst) begin
    if (bias_rst) begin
      for (int k = 0; k < NUM_CH; k++) begin
        r_shadow[k] <= '0;
        r_active[k] <= '0;
      end
      r_load_count   <= '0;
      r_active_valid <= 1'b0;
      r_err_overflow <= 1'b0;
      r_rd_data      <= '0;
    end else begin
      if (w_accept) begin
        r_shadow[r_load_count[IDX_W-1:0]] <= bus.in_data;
        r_load_count                      <= r_load_count + 1'b1;
      end else if (w_restart) begin
        r_load_count <= '0;
      end
      if (w_commit) begin
        r_active       <= r_shadow;
        r_active_valid <= 1'b1;
      end
      if (w_err_set) begin
        r_err_overflow <= 1'b1;
      end else if (w_restart) begin
        r_err_overflow <= 1'b0;
      end
      r_rd_data <= sext(w_rd_src);
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_flat
    assign bus.bias_flat[k*OUT_W +: OUT_W] = sext(r_active[k]);
  end

  assign bus.in_ready     = r_in_ready;
  assign bus.load_done    = r_load_done;
  assign bus.load_count   = r_load_count;
  assign bus.active_valid = r_active_valid;
  assign bus.err_overflow = r_err_overflow;
  assign bus.rd_data      = r_rd_data;

endmodule
`default_nettype wire

// File: tb/tb_bias_bank_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_bias_bank_buffer                                             |
// | Purpose  : Self-checking bench for bias_bank_buffer (NUM_CH=4, BIAS_W=16,  |
// |            OUT_W=24): vector table, directed corner sequences and random   |
// |            traffic against a queue-based reference model.                 |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_bias_bank_buffer;
  localparam int NUM_CH = 4;
  localparam int BIAS_W = 16;
  localparam int OUT_W  = 24;

  logic clk;
  logic bias_rst;
  int   n_chk  = 0;
  int   n_fail = 0;

  bias_bank_buffer_if #(.NUM_CH(NUM_CH), .BIAS_W(BIAS_W), .OUT_W(OUT_W)) bus ();

  bias_bank_buffer #(.NUM_CH(NUM_CH), .BIAS_W(BIAS_W), .OUT_W(OUT_W)) dut (
    .clk      (clk),
    .bias_rst (bias_rst),
    .bus      (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

  // Reference model: mode 0 idle, 1 loading, 2 full. Pending beats are a queue.
  int          m_mode;
  logic [15:0] m_q[$];
  logic [15:0] m_act [NUM_CH];
  bit          m_av;
  bit          m_err;
  logic [23:0] m_rd;

  function automatic logic [23:0] sx(input logic [15:0] b);
    return {{8{b[15]}}, b};
  endfunction

  task automatic model_reset();
    m_mode = 0;
    m_q.delete();
    for (int k = 0; k < NUM_CH; k++) m_act[k] = '0;
    m_av  = 0;
    m_err = 0;
    m_rd  = '0;
  endtask

  task automatic model_edge(input bit ls, input bit iv, input logic [15:0] d,
                            input bit sw, input logic [1:0] idx);
    int pre;
    pre = m_mode;
    if (pre == 2 && sw) begin
      for (int k = 0; k < NUM_CH; k++) m_act[k] = m_q[k];
      m_av   = 1;
      m_mode = 0;
    end
    if (pre == 1 && !ls && iv) begin
      m_q.push_back(d);
      if (m_q.size() == NUM_CH) m_mode = 2;
    end
    if (ls) begin
      m_mode = 1;
      m_q.delete();
      m_err  = 0;
    end
    if (pre != 1 && iv) m_err = 1;
    m_rd = sx(m_act[idx]);
  endtask

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [95:0] model_flat();
    logic [95:0] f;
    for (int k = 0; k < NUM_CH; k++) f[k*24 +: 24] = sx(m_act[k]);
    return f;
  endfunction

  task automatic check_all();
    chk("in_ready",     128'(bus.in_ready),     128'(m_mode == 1));
    chk("load_done",    128'(bus.load_done),    128'(m_mode == 2));
    chk("load_count",   128'(bus.load_count),   128'(m_q.size()));
    chk("active_valid", 128'(bus.active_valid), 128'(m_av));
    chk("err_overflow", 128'(bus.err_overflow), 128'(m_err));
    chk("bias_flat",    128'(bus.bias_flat),    128'(model_flat()));
    chk("rd_data",      128'(bus.rd_data),      128'(m_rd));
  endtask

  task automatic step(input bit ls, input bit iv, input logic [15:0] d,
                      input bit sw, input logic [1:0] idx);
    bus.load_start = ls;
    bus.in_valid   = iv;
    bus.in_data    = d;
    bus.swap       = sw;
    bus.rd_idx     = idx;
    @(posedge clk);
    model_edge(ls, iv, d, sw, idx);
    #1;
    check_all();
  endtask

  typedef struct {
    bit          ls;
    bit          iv;
    logic [15:0] d;
    bit          sw;
    logic [1:0]  idx;
    bit          rdy;
    bit          done;
    logic [2:0]  cnt;
    bit          av;
    logic [23:0] rd;
  } vec_t;

  vec_t tv [8];

  initial begin
    logic [15:0] ov_set [4];
    ov_set[0] = 16'hAAAA; ov_set[1] = 16'h5555; ov_set[2] = 16'h0F0F; ov_set[3] = 16'hF0F0;

    // Back-to-back load, swap, indexed reads
    tv[0] = '{1, 0, 16'h0000, 0, 2'd0, 1, 0, 3'd0, 0, 24'h000000};
    tv[1] = '{0, 1, 16'h0001, 0, 2'd0, 1, 0, 3'd1, 0, 24'h000000};
    tv[2] = '{0, 1, 16'hFFFF, 0, 2'd0, 1, 0, 3'd2, 0, 24'h000000};
    tv[3] = '{0, 1, 16'h7FFF, 0, 2'd0, 1, 0, 3'd3, 0, 24'h000000};
    tv[4] = '{0, 1, 16'h8000, 0, 2'd0, 0, 1, 3'd4, 0, 24'h000000};
    tv[5] = '{0, 0, 16'h0000, 1, 2'd1, 0, 0, 3'd4, 1, 24'hFFFFFF};
    tv[6] = '{0, 0, 16'h0000, 0, 2'd3, 0, 0, 3'd4, 1, 24'hFF8000};
    tv[7] = '{0, 0, 16'h0000, 0, 2'd2, 0, 0, 3'd4, 1, 24'h007FFF};

    bus.load_start = 0; bus.in_valid = 0; bus.in_data = '0; bus.swap = 0; bus.rd_idx = '0;
    model_reset();

    // Reset values, asserted between clock edges
    bias_rst = 1'b0;
    #2 bias_rst = 1'b1;
    #1;
    check_all();
    chk("rst_in_ready", 128'(bus.in_ready), 128'(0));
    #4 bias_rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      step(tv[i].ls, tv[i].iv, tv[i].d, tv[i].sw, tv[i].idx);
      chk($sformatf("tv%0d_ready", i), 128'(bus.in_ready),     128'(tv[i].rdy));
      chk($sformatf("tv%0d_done", i),  128'(bus.load_done),    128'(tv[i].done));
      chk($sformatf("tv%0d_count", i), 128'(bus.load_count),   128'(tv[i].cnt));
      chk($sformatf("tv%0d_valid", i), 128'(bus.active_valid), 128'(tv[i].av));
      chk($sformatf("tv%0d_rd", i),    128'(bus.rd_data),      128'(tv[i].rd));
    end
    chk("b2b_flat", 128'(bus.bias_flat), 128'(96'hFF8000_007FFF_FFFFFF_000001));

    // Gapped stream: valid every other cycle
    step(1, 0, 16'h0, 0, 2'd0);
    for (int i = 0; i < 8; i++) begin
      step(0, (i % 2) == 0, 16'(16'h0100 + i), 0, 2'(i % 4));
      if (i == 5) chk("gap_not_done", 128'(bus.load_done), 128'(0));
    end
    chk("gap_done",  128'(bus.load_done),  128'(1));
    chk("gap_count", 128'(bus.load_count), 128'(4));
    step(0, 0, 16'h0, 1, 2'd1);
    chk("gap_rd1", 128'(bus.rd_data), 128'(24'h000102));

    // Overflow in FULL
    step(1, 0, 16'h0, 0, 2'd0);
    for (int i = 0; i < 4; i++) step(0, 1, ov_set[i], 0, 2'd0);
    step(0, 1, 16'h1234, 0, 2'd0);
    chk("ovf_err",   128'(bus.err_overflow), 128'(1));
    chk("ovf_count", 128'(bus.load_count),   128'(4));
    step(0, 0, 16'h0, 1, 2'd3);
    chk("ovf_flat", 128'(bus.bias_flat), 128'(96'hFFF0F0_000F0F_005555_FFAAAA));
    chk("ovf_sticky", 128'(bus.err_overflow), 128'(1));
    step(1, 0, 16'h0, 0, 2'd0);
    chk("ovf_clear", 128'(bus.err_overflow), 128'(0));

    // Double buffering: active holds until swap; swap+load_start together
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 16'(16'h0010 + i), 0, 2'd0);
      chk("dbuf_hold", 128'(bus.bias_flat), 128'(96'hFFF0F0_000F0F_005555_FFAAAA));
    end
    step(1, 0, 16'h0, 1, 2'd2);
    chk("dbuf_flat",  128'(bus.bias_flat),  128'(96'h000013_000012_000011_000010));
    chk("dbuf_ready", 128'(bus.in_ready),   128'(1));
    chk("dbuf_count", 128'(bus.load_count), 128'(0));

    // Reset mid-load over a valid active bank
    step(0, 1, 16'h0BAD, 0, 2'd0);
    step(0, 1, 16'h0BEE, 0, 2'd0);
    bus.in_valid = 0;
    #3 bias_rst = 1'b1;
    #1;
    model_reset();
    check_all();
    chk("mrst_valid", 128'(bus.active_valid), 128'(0));
    chk("mrst_flat",  128'(bus.bias_flat),    128'(0));
    #1 bias_rst = 1'b0;
    step(1, 0, 16'h0, 0, 2'd0);
    for (int i = 0; i < 4; i++) step(0, 1, 16'(16'hC000 + i), 0, 2'd0);
    step(0, 0, 16'h0, 1, 2'd0);
    chk("mrst_reload", 128'(bus.bias_flat), 128'(96'hFFC003_FFC002_FFC001_FFC000));

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(15, 0) == 0,
           $urandom_range(3, 0) != 0,
           16'($urandom),
           $urandom_range(2, 0) == 0,
           2'($urandom_range(3, 0)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
